delay_checker: RTL and testbench
================================

DELAY_CHECKER -- requirements
Module: delay_checker

Interface
REQ-001 Parameter DEPTH, default 16: number of integer delay candidates, 0..DEPTH-1.
REQ-002 Parameter WINDOW, default 32: consecutive matching samples required to declare lock.
REQ-003 Parameter TOL, default 16: maximum allowed absolute difference, in LSB, for a sample to match.
REQ-004 Parameter LOSS, default 4: consecutive mismatches in TRACK that force a re-search.
REQ-005 clk_testsignal  in  1  sample clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse; starts or restarts measurement.
REQ-008 src_signal  in  16  reference test signal, signed two's complement.
REQ-009 dut_signal  in  16  delayed signal under test, signed two's complement.
REQ-010 busy  out  1  high in FILL and SEARCH.
REQ-011 locked  out  1  high in TRACK.
REQ-012 fail  out  1  high in FAIL; no candidate matched.
REQ-013 delay_est  out  clog2(DEPTH)  locked delay in samples; holds last locked value otherwise.
REQ-014 err_count  out  16  mismatches counted in TRACK, saturating at 16'hFFFF.

Function
REQ-015 History: shift register h[0..DEPTH-1] of src_signal, shifted every edge in all states; h[0] = sample from previous edge.
REQ-016 Candidate k compares dut_signal at edge n with src_signal at edge n-k: k=0 uses src_signal directly, k>=1 uses h[k-1].
REQ-017 Match: |dut - src(n-k)| <= TOL, computed on 17-bit sign-extended difference; no overflow at full-scale extremes (16'h7FFF vs 16'h8000 gives diff 65535).
REQ-018 FSM states: IDLE, FILL, SEARCH, TRACK, FAIL; encoding free.
REQ-019 IDLE: outputs inert; start -> FILL.
REQ-020 FILL: counts DEPTH-1 edges, then -> SEARCH with k=0, match run counter=0.
REQ-021 SEARCH: match on candidate k increments run counter; run reaching WINDOW -> TRACK, delay_est<=k, err_count<=0.
REQ-022 SEARCH: mismatch -> run counter=0, k<=k+1; mismatch at k=DEPTH-1 -> FAIL (no wrap to 0).
REQ-023 TRACK: compare at candidate delay_est every edge; mismatch increments err_count (saturating) and consecutive-miss counter; match clears consecutive-miss counter.
REQ-024 TRACK: consecutive-miss counter reaching LOSS -> SEARCH at k=0, run=0; delay_est and err_count hold.
REQ-025 FAIL: holds until start or reset.
REQ-026 start in any state (including simultaneous with a match or loss event) -> FILL, counters cleared, start wins; delay_est holds.
REQ-027 Status outputs registered: state change visible one edge after the deciding comparison edge.

Reset
REQ-028 reset low: state IDLE, h[] all 0, busy=0, locked=0, fail=0, delay_est=0, err_count=0, all internal counters 0.
REQ-029 reset asserted mid-operation aborts immediately; after release block waits in IDLE for start.

Verification
REQ-030 Ramp src (+5 per edge, 16-bit wrap), dut=src delayed 2, start -> busy for DEPTH-1+2*1+WINDOW edges approx, then locked=1, delay_est=2, err_count=0.
REQ-031 dut=src delayed 0 -> lock at k=0 after DEPTH-1+WINDOW edges; dut=src+TOL locks, dut=src+TOL+1 never locks.
REQ-032 dut=constant 0 with ramp src -> fail=1 after all 16 candidates reject; locked stays 0; start re-arms to FILL.
REQ-033 Locked at delay 2, inject 3 isolated bad samples -> err_count=3, stays locked; inject 4 consecutive -> busy=1, re-lock at delay 2, err_count holds 7 until relock clears it to 0.
REQ-034 Src 16'h7FFF, dut 16'h8000 -> mismatch (no wrap-around false match).
REQ-035 reset pulse during SEARCH -> all outputs 0 next cycle; start after release repeats REQ-030 result.

Source files
------------

// File: rtl/delay_checker.sv
// rtl/delay_checker.sv - measures the integer sample delay between a reference and a delayed signal
//
// Keeps a history of src_signal and tries delay candidates 0..DEPTH-1 in turn.
// A candidate that matches for WINDOW consecutive samples becomes the locked
// delay. The lock is then tracked until LOSS consecutive mismatches force a
// new search.
//
// Ports
//   clk_testsignal  sample clock, rising edge
//   reset           asynchronous, active-low
//   start           one-cycle pulse; starts or restarts a measurement
//   src_signal      reference signal, signed 16-bit
//   dut_signal      delayed signal under test, signed 16-bit
//   busy            high while filling history or searching
//   locked          high while tracking a locked delay
//   fail            high when no candidate matched
//   delay_est       last locked delay, in samples
//   err_count       mismatches seen while tracking, saturating
module delay_checker #(
  parameter int DEPTH  = 16,
  parameter int WINDOW = 32,
  parameter int TOL    = 16,
  parameter int LOSS   = 4,
  localparam int KW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_testsignal,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   src_signal,
  input  logic [15:0]   dut_signal,
  output logic          busy,
  output logic          locked,
  output logic          fail,
  output logic [KW-1:0] delay_est,
  output logic [15:0]   err_count
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(WINDOW + 1);
  localparam int MW = $clog2(LOSS + 1);

  localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 2);
  localparam logic [RW-1:0] WIN_LAST  = RW'(WINDOW - 1);
  localparam logic [MW-1:0] LOSS_LAST = MW'(LOSS - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(DEPTH - 1);
  localparam logic [16:0]   TOL_V     = 17'(TOL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SEARCH,
    S_TRACK,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     hist_q [DEPTH];
  logic [15:0]     hist_d [DEPTH];
  logic [KW-1:0]   k_q, k_d;
  logic [RW-1:0]   run_q, run_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [KW-1:0]   delay_q, delay_d;
  logic [15:0]     err_q, err_d;
  logic            busy_q, busy_d;
  logic            locked_q, locked_d;
  logic            fail_q, fail_d;

  logic [KW-1:0]   cand_idx;
  logic [15:0]     cand_val;
  logic [16:0]     diff;
  logic [16:0]     mag;
  logic            match;

  // History shifts every edge regardless of state; h[0] holds last edge's sample.
  always_comb begin
    hist_d[0] = src_signal;
    for (int i = 1; i < DEPTH; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  // One shared comparator: TRACK checks the locked delay, otherwise the search candidate.
  // Difference is taken on 17 bits so full-scale opposite extremes cannot wrap into a match.
  always_comb begin
    cand_idx = (state_q == S_TRACK) ? delay_q : k_q;
    cand_val = (cand_idx == '0) ? src_signal : hist_q[cand_idx - 1'b1];
    diff     = {dut_signal[15], dut_signal} - {cand_val[15], cand_val};
    mag      = diff[16] ? (~diff + 17'd1) : diff;
    match    = (mag <= TOL_V);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    run_d   = run_q;
    miss_d  = miss_q;
    fill_d  = fill_q;
    delay_d = delay_q;
    err_d   = err_q;

    if (start) begin
      // start overrides any lock/loss decision made on the same edge
      state_d = S_FILL;
      k_d     = '0;
      run_d   = '0;
      miss_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end

        S_FILL: begin
          if (DEPTH < 2 || fill_q == FILL_LAST) begin
            state_d = S_SEARCH;
            fill_d  = '0;
            k_d     = '0;
            run_d   = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        S_SEARCH: begin
          if (match) begin
            if (run_q == WIN_LAST) begin
              state_d = S_TRACK;
              delay_d = k_q;
              err_d   = '0;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
            // the last candidate failing ends the measurement; no wrap back to 0
            if (k_q == K_LAST) begin
              state_d = S_FAIL;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end

        S_TRACK: begin
          if (match) begin
            miss_d = '0;
          end else begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (miss_q == LOSS_LAST) begin
              state_d = S_SEARCH;
              k_d     = '0;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end

        S_FAIL: begin
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d   = (state_d == S_FILL) || (state_d == S_SEARCH);
    locked_d = (state_d == S_TRACK);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge clk_testsignal or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      k_q      <= '0;
      run_q    <= '0;
      miss_q   <= '0;
      fill_q   <= '0;
      delay_q  <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
      k_q      <= k_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      fill_q   <= fill_d;
      delay_q  <= delay_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  assign busy      = busy_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign delay_est = delay_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_delay_checker.sv
// tb/tb_delay_checker.sv - self-checking bench for delay_checker
module tb_delay_checker;

  localparam int DEPTH  = 16;
  localparam int WINDOW = 32;
  // tolerance below the 5-LSB ramp step so neighbouring candidates reject
  localparam int TOL    = 4;
  localparam int LOSS   = 4;

  typedef logic [22:0] outcome_t; // {busy, locked, fail, delay_est[3:0], err_count[15:0]}

  logic        clk_testsignal = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_signal = '0;
  logic [15:0] dut_signal = '0;
  logic        busy;
  logic        locked;
  logic        fail;
  logic [3:0]  delay_est;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  outcome_t exp_q[$];

  logic [15:0] sh [8];
  int          dly = 0;
  logic [15:0] ofs = '0;
  bit          bad = 1'b0;
  bit          src_const = 1'b0;
  bit          dut_const = 1'b0;
  logic [15:0] src_cval = '0;
  logic [15:0] dut_cval = '0;

  delay_checker #(
    .DEPTH(DEPTH),
    .WINDOW(WINDOW),
    .TOL(TOL),
    .LOSS(LOSS)
  ) dut (
    .clk_testsignal(clk_testsignal),
    .reset(reset),
    .start(start),
    .src_signal(src_signal),
    .dut_signal(dut_signal),
    .busy(busy),
    .locked(locked),
    .fail(fail),
    .delay_est(delay_est),
    .err_count(err_count)
  );

  always #5 clk_testsignal = ~clk_testsignal;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic outcome_t obs();
    return {busy, locked, fail, delay_est, err_count};
  endfunction

  task automatic apply();
    src_signal = sh[0];
    dut_signal = dut_const ? dut_cval : (sh[dly] + ofs + (bad ? 16'd1000 : 16'd0));
  endtask

  task automatic tick();
    @(posedge clk_testsignal);
    #1;
    for (int i = 7; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = src_const ? src_cval : (sh[0] + 16'd5);
    apply();
  endtask

  task automatic restart(input int d, input logic [15:0] o);
    src_const = 1'b0;
    dut_const = 1'b0;
    bad = 1'b0;
    dly = d;
    ofs = o;
    for (int i = 0; i < 8; i++) sh[i] = 16'(1000 - 5 * i);
    apply();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_outcome(input int budget, output int cyc);
    cyc = 0;
    while (!(locked || fail) && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    outcome_t e;
    reset = 1'b0;
    restart(0, 16'd0);
    repeat (3) tick();
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_state obs=%h exp=%h", obs(), e);
    end
    reset = 1'b1;
    repeat (4) tick();
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL idle_after_release obs=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_lock_delay2();
    outcome_t e;
    int cyc;
    int lat;
    restart(2, 16'd0);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd2, 16'd0});
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL d2_busy_after_start obs=%b exp=1", busy);
    end
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL d2_outcome obs=%h exp=%h", obs(), e);
    end
    lat = DEPTH - 1 + 2 + WINDOW;
    checks++;
    if (cyc < lat - 2 || cyc > lat + 2) begin
      errors++;
      $display("FAIL d2_latency obs=%0d exp=%0d+-2", cyc, lat);
    end
  endtask

  task automatic test_fail_const();
    outcome_t e;
    int cyc;
    restart(0, 16'd0);
    dut_const = 1'b1;
    dut_cval = 16'd0;
    apply();
    exp_q.push_back({1'b0, 1'b0, 1'b1, 4'd2, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL const_zero_fail obs=%h exp=%h", obs(), e);
    end
    repeat (3) tick();
    exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd2, 16'd0});
    pulse_start();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL fail_rearm obs=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_lock_delay0();
    outcome_t e;
    int cyc;
    int lat;
    restart(0, 16'd0);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd0, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL d0_outcome obs=%h exp=%h", obs(), e);
    end
    lat = DEPTH - 1 + WINDOW;
    checks++;
    if (cyc < lat - 2 || cyc > lat + 2) begin
      errors++;
      $display("FAIL d0_latency obs=%0d exp=%0d+-2", cyc, lat);
    end
  endtask

  task automatic test_tolerance();
    outcome_t e;
    int cyc;
    restart(0, 16'(TOL));
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd0, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL tol_edge_locks obs=%h exp=%h", obs(), e);
    end
    restart(0, 16'(TOL + 1));
    exp_q.push_back({1'b0, 1'b0, 1'b1, 4'd0, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL tol_plus1_rejects obs=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_fullscale();
    outcome_t e;
    int cyc;
    restart(0, 16'd0);
    src_const = 1'b1;
    src_cval = 16'h7FFF;
    dut_const = 1'b1;
    dut_cval = 16'h8000;
    sh[0] = 16'h7FFF;
    apply();
    exp_q.push_back({1'b0, 1'b0, 1'b1, 4'd0, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL fullscale_no_wrap obs=%h exp=%h", obs(), e);
    end
    dut_cval = 16'h7FFF;
    apply();
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd0, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL fullscale_equal_locks obs=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_track_errors();
    outcome_t e;
    int cyc;
    restart(2, 16'd0);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd2, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL track_initial_lock obs=%h exp=%h", obs(), e);
    end
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd2, 16'd3});
    for (int n = 0; n < 3; n++) begin
      bad = 1'b1;
      tick();
      bad = 1'b0;
      repeat (3) tick();
    end
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL isolated_errors obs=%h exp=%h", obs(), e);
    end
    exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd2, 16'd7});
    bad = 1'b1;
    repeat (4) tick();
    bad = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL loss_to_search obs=%h exp=%h", obs(), e);
    end
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd2, 16'd0});
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL relock obs=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_reset_mid();
    outcome_t e;
    int cyc;
    int lat;
    restart(2, 16'd0);
    pulse_start();
    repeat (20) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before_reset obs=%b exp=1", busy);
    end
    reset = 1'b0;
    #1;
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL mid_reset_immediate obs=%h exp=%h", obs(), e);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL mid_reset_idle obs=%h exp=%h", obs(), e);
    end
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd2, 16'd0});
    pulse_start();
    wait_outcome(300, cyc);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL mid_reset_relock obs=%h exp=%h", obs(), e);
    end
    lat = DEPTH - 1 + 2 + WINDOW;
    checks++;
    if (cyc < lat - 2 || cyc > lat + 2) begin
      errors++;
      $display("FAIL mid_reset_latency obs=%0d exp=%0d+-2", cyc, lat);
    end
  endtask

  initial begin
    test_reset();
    test_lock_delay2();
    test_fail_const();
    test_lock_delay0();
    test_tolerance();
    test_fullscale();
    test_track_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
